// File: rtl/climb_pkg.sv
// Shared types and defaults for the climbing-game scroll controller.
// Latency: n/a (types and functions only); no backpressure.
package climb_pkg;

  typedef enum logic [1:0] {
    FREEFALL = 2'd0,
    ANCHORED = 2'd1,
    EDIT     = 2'd2
  } state_t;

  localparam int TOP_LIMIT_DEF = -2000;
  localparam int CENTER_X_DEF  = 512;
  localparam int CENTER_Y_DEF  = 384;

  // Clip a wide signed result into the range of a w-bit signed value.
  function automatic int saturate(input int v, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/hand_select.sv
// Combinational lowest-index picker over a request vector.
// Latency: 0 clocks; no backpressure.
module hand_select #(
  parameter int N  = 2,
  parameter int AW = 1
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [AW-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = AW'(i);
      end
    end
  end

endmodule

// File: rtl/climb_scroll_ctrl.sv
// Per-frame screen-origin controller: anchored drag, gravity free-fall and edit-mode pan.
// Latency: 1 clock from the sampled vsync rise to new outputs; no backpressure (one update per frame).
module climb_scroll_ctrl
  import climb_pkg::*;
#(
  parameter int NUM_HANDS  = 2,
  parameter int HX_W       = 11,
  parameter int HY_W       = 10,
  parameter int SX_W       = 12,
  parameter int SY_W       = 13,
  parameter int TOP_LIMIT  = TOP_LIMIT_DEF,
  parameter int GRAV_DIV   = 2,
  parameter int MAX_FALL   = 24,
  parameter int EDIT_SHIFT = 1,
  parameter int CENTER_X   = CENTER_X_DEF,
  parameter int CENTER_Y   = CENTER_Y_DEF,
  localparam int AW        = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1
) (
  input  logic                        clock_65mhz,
  input  logic                        reset,
  input  logic                        vsync,
  input  logic                        mode_edit,
  input  logic [NUM_HANDS*HX_W-1:0]   hand_x,
  input  logic [NUM_HANDS*HY_W-1:0]   hand_y,
  input  logic [NUM_HANDS-1:0]        hand_grab,
  output logic signed [SX_W-1:0]      screen_x,
  output logic signed [SY_W-1:0]      screen_y,
  output logic [AW-1:0]               anchor_idx,
  output logic                        anchor_valid,
  output logic                        falling,
  output logic                        update_strobe
);

  localparam int CW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;

  logic                   vsync_d;
  logic                   tick;
  logic [NUM_HANDS-1:0]   grab_prev;
  logic [NUM_HANDS-1:0]   pulse;
  state_t                 state;
  state_t                 state_n;
  logic                   pulse_vld;
  logic                   held_vld;
  logic [AW-1:0]          pulse_idx;
  logic [AW-1:0]          held_idx;
  logic [AW-1:0]          aidx_n;
  logic                   capture;
  logic signed [SX_W-1:0] last_x;
  logic signed [SY_W-1:0] last_y;
  logic signed [SX_W:0]   vx;
  logic signed [SX_W:0]   vx_n;
  logic signed [SY_W:0]   vy;
  logic signed [SY_W:0]   vy_n;
  logic [CW-1:0]          grav_cnt;
  logic [CW-1:0]          cnt_n;
  logic [HX_W-1:0]        hold_hx;
  logic [HY_W-1:0]        hold_hy;
  logic signed [SX_W-1:0] hold_sx;
  logic signed [SY_W-1:0] hold_sy;
  logic [HX_W-1:0]        hxa [NUM_HANDS];
  logic [HY_W-1:0]        hya [NUM_HANDS];
  int                     nx;
  int                     ny;

  assign tick  = vsync & ~vsync_d;
  assign pulse = hand_grab & ~grab_prev;

  always_comb begin
    for (int i = 0; i < NUM_HANDS; i++) begin
      hxa[i] = hand_x[i*HX_W +: HX_W];
      hya[i] = hand_y[i*HY_W +: HY_W];
    end
  end

  hand_select #(.N(NUM_HANDS), .AW(AW)) u_pulse_sel (
    .req   (pulse),
    .valid (pulse_vld),
    .idx   (pulse_idx)
  );

  hand_select #(.N(NUM_HANDS), .AW(AW)) u_held_sel (
    .req   (hand_grab),
    .valid (held_vld),
    .idx   (held_idx)
  );

  always_comb begin
    state_n = state;
    aidx_n  = anchor_idx;
    vx_n    = vx;
    vy_n    = vy;
    cnt_n   = grav_cnt;
    capture = 1'b0;
    nx      = int'(screen_x);
    ny      = int'(screen_y);

    if (mode_edit) begin
      state_n = EDIT;
      vx_n    = '0;
      vy_n    = '0;
    end else if (pulse_vld) begin
      state_n = ANCHORED;
      aidx_n  = pulse_idx;
      capture = 1'b1;
    end else if (state == ANCHORED && !hand_grab[anchor_idx] && held_vld) begin
      aidx_n  = held_idx;
      capture = 1'b1;
    end else if (!held_vld) begin
      state_n = FREEFALL;
      // Entering free-fall carries the last frame's motion as momentum.
      if (state != FREEFALL) begin
        vx_n  = (SX_W+1)'(int'(screen_x) - int'(last_x));
        vy_n  = (SY_W+1)'(int'(screen_y) - int'(last_y));
        cnt_n = '0;
      end
    end

    case (state_n)
      ANCHORED: begin
        if (!capture) begin
          nx = int'(hold_sx) - (int'(hxa[aidx_n]) - int'(hold_hx));
          ny = int'(hold_sy) - (int'(hya[aidx_n]) - int'(hold_hy));
        end
      end
      FREEFALL: begin
        nx = int'(screen_x) + int'(vx_n);
        ny = int'(screen_y) + int'(vy_n);
        if (int'(cnt_n) == GRAV_DIV - 1) begin
          cnt_n = '0;
          vy_n  = (int'(vy_n) >= MAX_FALL) ? (SY_W+1)'(MAX_FALL) : (SY_W+1)'(int'(vy_n) + 1);
        end else begin
          cnt_n = cnt_n + CW'(1);
        end
      end
      EDIT: begin
        nx = int'(screen_x) + ((int'(hxa[0]) - int'(screen_x) - CENTER_X) >>> EDIT_SHIFT);
        ny = int'(screen_y) + ((int'(hya[0]) - int'(screen_y) - CENTER_Y) >>> EDIT_SHIFT);
      end
      default: ;
    endcase

    nx = saturate(nx, SX_W);
    ny = saturate(ny, SY_W);
    if (ny > 0) begin
      ny   = 0;
      vy_n = '0;
    end
    if (ny < TOP_LIMIT) begin
      ny   = TOP_LIMIT;
      vy_n = '0;
    end
  end

  always_ff @(posedge clock_65mhz or posedge reset) begin
    if (reset) begin
      vsync_d       <= 1'b0;
      update_strobe <= 1'b0;
      grab_prev     <= '0;
      state         <= FREEFALL;
      anchor_idx    <= '0;
      anchor_valid  <= 1'b0;
      falling       <= 1'b0;
      vx            <= '0;
      vy            <= '0;
      grav_cnt      <= '0;
      last_x        <= '0;
      last_y        <= '0;
      screen_x      <= '0;
      screen_y      <= '0;
      hold_hx       <= '0;
      hold_hy       <= '0;
      hold_sx       <= '0;
      hold_sy       <= '0;
    end else begin
      vsync_d       <= vsync;
      update_strobe <= tick;
      if (tick) begin
        grab_prev    <= hand_grab;
        state        <= state_n;
        anchor_idx   <= aidx_n;
        anchor_valid <= (state_n == ANCHORED);
        falling      <= (state_n == FREEFALL);
        vx           <= vx_n;
        vy           <= vy_n;
        grav_cnt     <= cnt_n;
        last_x       <= screen_x;
        last_y       <= screen_y;
        screen_x     <= SX_W'(nx);
        screen_y     <= SY_W'(ny);
        if (capture) begin
          hold_hx <= hxa[aidx_n];
          hold_hy <= hya[aidx_n];
          hold_sx <= screen_x;
          hold_sy <= screen_y;
        end
      end
    end
  end

endmodule

// File: doc/climb_scroll_ctrl.md
Name: climb_scroll_ctrl

Overview:
- Per-frame screen-scroll controller for the climbing game. Generalises the two-hand movement logic to NUM_HANDS hands, with parametrised coordinate widths and a clocked design.
- Adds an explicit state machine, a velocity register with capped gravity, saturating arithmetic, and top/ground clamps.
- Map-editor mode is a defined pan mode.
- Sits between the hand-tracking front end and the renderer. Produces the screen origin once per frame.

Parameters:
- NUM_HANDS, 2, number of tracked hands (1..4).
- HX_W, 11, hand x width (unsigned pixels).
- HY_W, 10, hand y width (unsigned pixels).
- SX_W, 12, screen_x width (signed).
- SY_W, 13, screen_y width (signed; negative is up).
- TOP_LIMIT, -2000, minimum screen_y.
- GRAV_DIV, 2, frames per +1 increment of vy.
- MAX_FALL, 24, vy saturation (pixels/frame).
- EDIT_SHIFT, 1, edit-mode pan divisor exponent.
- CENTER_X, 512, screen centre x.
- CENTER_Y, 384, screen centre y.

Ports:
- clock_65mhz  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- vsync  in  1  raw vsync; its rising edge defines the frame tick.
- mode_edit  in  1  map-editor mode enable.
- hand_x  in  NUM_HANDS*HX_W  packed hand x; hand i is at [i*HX_W +: HX_W].
- hand_y  in  NUM_HANDS*HY_W  packed hand y.
- hand_grab  in  NUM_HANDS  per-hand grab level.
- screen_x  out  SX_W  signed screen origin x.
- screen_y  out  SY_W  signed screen origin y.
- anchor_idx  out  clog2(NUM_HANDS) (minimum 1)  current anchoring hand.
- anchor_valid  out  1  high in ANCHORED.
- falling  out  1  high in FREEFALL.
- update_strobe  out  1  one-cycle pulse when screen_x/screen_y have just been updated.

Behaviour:
- Reset (async, active-high): all outputs and all state registers are 0. vsync_d=0, grab_prev=0, vx=vy=0, grav_cnt=0, state=FREEFALL.
- Frame tick: tick = vsync & ~vsync_d, with vsync_d registered every clock. All frame registers update only on the clock edge where tick=1. update_strobe is high for the following cycle. Latency is 1 clock from the sampled vsync rise to the new outputs.
- Grab pulses: pulse[i] = hand_grab[i] & ~grab_prev[i]. grab_prev updates on ticks only. A hand held through reset pulses on the first tick.
- States: FREEFALL, ANCHORED, EDIT. On each tick, evaluate the transitions in this priority order:
  1. mode_edit=1 -> EDIT. Clear anchor_valid; vx=vy=0.
  2. Any pulse -> ANCHORED on the lowest-index pulsing hand. Capture hold_hand = that hand's (x, y) and hold_scr = (screen_x, screen_y).
  3. ANCHORED and the anchor hand released, with some other hand held -> re-anchor to the lowest-index held hand. Capture hold_hand and hold_scr again.
  4. No hand grabbing -> FREEFALL. On entry, vx = screen_x - prev_x and vy = screen_y - prev_y (last-frame delta), and grav_cnt=0.
  5. Otherwise stay in the current state.
- Position update on the same tick, where prev_* is the screen value before this tick:
  - ANCHORED: scr = hold_scr - (hand[anchor] - hold_hand). Hand values are zero-extended to SX_W+1/SY_W+1 bits. On the capture tick itself the screen is unchanged.
  - FREEFALL: scr = scr + (vx, vy). grav_cnt increments modulo GRAV_DIV. When it wraps, vy = min(vy+1, MAX_FALL). vx is constant.
  - EDIT: scr += (hand0 - scr - CENTER) >>> EDIT_SHIFT, using an arithmetic shift and computed at SX_W+1/SY_W+1 bits.
- Clamps, applied after the update, in this order:
  - Results are computed wide, then saturated to SX_W/SY_W.
  - If y > 0: y = 0 and vy = 0 (ground).
  - If y < TOP_LIMIT: y = TOP_LIMIT and vy = 0.
  - x only saturates.
- Simultaneous pulses on several hands: the lowest index wins. Anchor release and a new pulse on the same tick: rule 2 wins.
- Reset asserted mid-frame: everything returns to the reset values immediately. The first tick after release follows normal rules.
- No tick: every register holds and update_strobe=0.

Decomposition:
- climb_pkg holds:
  - the state enum: FREEFALL=0, ANCHORED=1, EDIT=2;
  - the saturate function;
  - the default constants TOP_LIMIT, CENTER_X, CENTER_Y.
- One sub-module, hand_select: a combinational priority picker.
  - Inputs: a NUM_HANDS request vector.
  - Outputs: valid and the lowest-index result. It is used twice, once for pulses and once for held hands.

Test Plan:
- Reset, then 3 ticks with no grabs -> screen (0,0), falling=1, y clamped at 0, vy=0.
- Hand0 grab at (300,500) on tick 1; hand0 moves to (300,560) by tick 2 -> screen_y=-60, anchor_idx=0, anchor_valid=1.
- Anchored on hand0; hand1 grabs at (400,200) while hand0 releases on the same tick -> anchor_idx=1, hold captured; a hand1 move of -10 in y gives screen_y +10.
- Release all hands at screen (0,-1000) after a frame delta of (3,-8) -> y per tick is -1008, -1016, -1023, -1030, -1036 (vy +1 every 2 ticks), x +3 per tick; vy saturates at MAX_FALL.
- mode_edit=1, screen (0,0), hand0 (612,384) -> screen_x 50, 75, 87 over 3 ticks; screen_y constant.
- Anchored drag to y=-2100 -> screen_y=TOP_LIMIT=-2000. Assert reset mid-frame -> outputs are 0 within the same cycle.
